// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Bimodal/gshare branch predictor. It has a 64-entry BHT of
//               2-bit saturating counters and a 16-entry direct-mapped BTB.
//               The fetch lookup is combinational. The resolve stage
//               registers the mispredict flag and the redirect PC.
//               Optional feature: define BRANCH_PRED_GSHARE_EN to XOR a
//               6-bit global history register into the BHT index.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [5:0]  pred_idx,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic [5:0]  ex_idx,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);

  localparam int         c_BHT_ENTRIES = 64;
  localparam int         c_BTB_ENTRIES = 16;
  localparam logic [1:0] c_CTR_RESET   = 2'd1;  // weakly not-taken
  localparam logic [1:0] c_CTR_MAX     = 2'd3;
  localparam logic [1:0] c_CTR_MIN     = 2'd0;

  logic [1:0]  r_bht       [0:c_BHT_ENTRIES-1];
  logic [15:0] r_btb_valid;
  logic [25:0] r_btb_tag   [0:c_BTB_ENTRIES-1];
  logic [31:0] r_btb_tgt   [0:c_BTB_ENTRIES-1];
  logic        r_mispredict;
  logic [31:0] r_redirect_pc;

  logic [5:0]  w_idx;
  logic [3:0]  w_btb_idx;
  logic        w_btb_hit;
  logic [1:0]  w_ctr;
  logic [3:0]  w_ex_btb_idx;
  logic        w_dir_miss;
  logic        w_tgt_miss;

  // ---------------------------------------------------------------------------
  // BHT indexing: plain PC bits, or PC bits folded with the resolved history
  // ---------------------------------------------------------------------------
`ifdef BRANCH_PRED_GSHARE_EN
  logic [5:0] r_ghr;

  // History advances only when a branch resolves, never at fetch time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= 6'd0;
    end else if (ex_valid) begin
      r_ghr <= {r_ghr[4:0], ex_taken};
    end
  end

  assign w_idx = if_pc[7:2] ^ r_ghr;
`else
  assign w_idx = if_pc[7:2];
`endif

  // ---------------------------------------------------------------------------
  // Combinational lookup against the current (pre-update) array contents
  // ---------------------------------------------------------------------------
  assign w_btb_idx   = if_pc[5:2];
  assign w_btb_hit   = r_btb_valid[w_btb_idx] && (r_btb_tag[w_btb_idx] == if_pc[31:6]);
  assign w_ctr       = r_bht[w_idx];
  assign pred_taken  = if_valid && w_btb_hit && w_ctr[1];
  assign pred_target = pred_taken ? r_btb_tgt[w_btb_idx] : (if_pc + 32'd4);
  assign pred_idx    = w_idx;

  // ---------------------------------------------------------------------------
  // BHT: one saturating counter per entry, trained at resolve
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < c_BHT_ENTRIES; gi++) begin : g_bht
      // Step this counter toward the resolved outcome when it is the one addressed
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_bht[gi] <= c_CTR_RESET;
        end else if (ex_valid && (ex_idx == 6'(gi))) begin
          if (ex_taken) begin
            if (r_bht[gi] != c_CTR_MAX) r_bht[gi] <= r_bht[gi] + 2'd1;
          end else begin
            if (r_bht[gi] != c_CTR_MIN) r_bht[gi] <= r_bht[gi] - 2'd1;
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // BTB: allocated/overwritten only by taken branches
  // ---------------------------------------------------------------------------
  assign w_ex_btb_idx = ex_pc[5:2];

  generate
    for (genvar gj = 0; gj < c_BTB_ENTRIES; gj++) begin : g_btb
      // Valid bit is the only BTB state that needs a reset value
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_btb_valid[gj] <= 1'b0;
        end else if (ex_valid && ex_taken && (w_ex_btb_idx == 4'(gj))) begin
          r_btb_valid[gj] <= 1'b1;
        end
      end

      // Tag and target are qualified by the valid bit, so they carry no reset
      always_ff @(posedge clk) begin
        if (ex_valid && ex_taken && (w_ex_btb_idx == 4'(gj))) begin
          r_btb_tag[gj] <= ex_pc[31:6];
          r_btb_tgt[gj] <= ex_target;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Resolution compare: register the flush request and the corrected fetch PC
  // ---------------------------------------------------------------------------
  assign w_dir_miss = ex_taken ^ ex_pred_taken;
  assign w_tgt_miss = ex_taken && ex_pred_taken && (ex_target != ex_pred_target);

  // Mispredict pulses for one cycle; redirect_pc keeps its value between resolves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mispredict  <= 1'b0;
      r_redirect_pc <= 32'd0;
    end else begin
      r_mispredict <= ex_valid && (w_dir_miss || w_tgt_miss);
      if (ex_valid) begin
        r_redirect_pc <= ex_taken ? ex_target : (ex_pc + 32'd4);
      end
    end
  end

  assign mispredict  = r_mispredict;
  assign redirect_pc = r_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Scoreboard bench for branch_predictor (default build, plain
//               PC indexing). The stimulus queues hand-computed expectations.
//               A monitor pops them and compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [5:0]  pred_idx;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [5:0]  ex_idx;
  logic        mispredict;
  logic [31:0] redirect_pc;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [5:0]  idx;
  } lk_t;

  typedef struct {
    logic        misp;
    logic [31:0] redir;
  } rs_t;

  lk_t         lk_q[$];
  rs_t         rs_q[$];
  lk_t         r_le;
  rs_t         r_re;
  int          checks;
  int          errors;
  logic        r_pend;
  logic [31:0] r_last_redir;

  branch_predictor u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_idx       (pred_idx),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .ex_idx         (ex_idx),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive a lookup for this cycle and queue its expected combinational result
  task automatic lookup(input logic v, input logic [31:0] pc,
                        input logic e_taken, input logic [31:0] e_tgt, input logic [5:0] e_idx);
    lk_t e;
    if_valid = v;
    if_pc    = pc;
    e.taken  = e_taken;
    e.target = e_tgt;
    e.idx    = e_idx;
    lk_q.push_back(e);
  endtask

  // Drive a resolve for this cycle and queue the expected registered response
  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                         input logic ptk, input logic [31:0] ptg, input logic [5:0] idx,
                         input logic e_misp, input logic [31:0] e_redir);
    rs_t e;
    ex_valid       = 1'b1;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tg;
    ex_pred_taken  = ptk;
    ex_pred_target = ptg;
    ex_idx         = idx;
    e.misp         = e_misp;
    e.redir        = e_redir;
    rs_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  // Note which edges carried a live resolve so the monitor knows what to expect
  always @(posedge clk) r_pend = ex_valid && rst_n;

  // Monitor: compare outputs mid-cycle against queued expectations
  always @(negedge clk) begin
    if (lk_q.size() > 0) begin
      r_le = lk_q.pop_front();
      chk("pred_taken",  {31'd0, pred_taken}, {31'd0, r_le.taken});
      chk("pred_target", pred_target, r_le.target);
      chk("pred_idx",    {26'd0, pred_idx}, {26'd0, r_le.idx});
    end
    if (!rst_n) begin
      if (r_pend && rs_q.size() > 0) void'(rs_q.pop_front());
      r_pend       = 1'b0;
      r_last_redir = 32'd0;
      chk("reset_mispredict",  {31'd0, mispredict}, 32'd0);
      chk("reset_redirect_pc", redirect_pc, 32'd0);
    end else if (r_pend) begin
      if (rs_q.size() == 0) begin
        chk("resolve_queue_underflow", 32'd1, 32'd0);
      end else begin
        r_re = rs_q.pop_front();
        chk("mispredict",  {31'd0, mispredict}, {31'd0, r_re.misp});
        chk("redirect_pc", redirect_pc, r_re.redir);
        r_last_redir = r_re.redir;
      end
    end else begin
      chk("idle_mispredict",  {31'd0, mispredict}, 32'd0);
      chk("idle_redirect_pc", redirect_pc, r_last_redir);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks         = 0;
    errors         = 0;
    r_pend         = 1'b0;
    r_last_redir   = 32'd0;
    rst_n          = 1'b0;
    if_valid       = 1'b0;
    if_pc          = 32'd0;
    ex_valid       = 1'b0;
    ex_pc          = 32'd0;
    ex_taken       = 1'b0;
    ex_target      = 32'd0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'd0;
    ex_idx         = 6'd0;
    @(posedge clk);
    #1;

    // In reset: nothing is valid in the BTB
    lookup(1'b1, 32'h100, 1'b0, 32'h104, 6'd0);
    tick();
    rst_n = 1'b1;
    lookup(1'b1, 32'h100, 1'b0, 32'h104, 6'd0);
    tick();

    // First taken resolve. The same-cycle lookup still sees the old state.
    lookup(1'b1, 32'h100, 1'b0, 32'h104, 6'd0);
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 6'd0, 1'b1, 32'h200);
    tick();
    lookup(1'b1, 32'h100, 1'b1, 32'h200, 6'd0);              // counter 2, BTB hit
    tick();
    lookup(1'b1, 32'h200, 1'b0, 32'h204, 6'd0);              // same BTB slot, tag miss
    tick();
    lookup(1'b0, 32'h100, 1'b0, 32'h104, 6'd0);              // no request, idx still driven
    tick();

    // Train down: 2 -> 1 -> 0 -> 0
    lookup(1'b1, 32'h100, 1'b1, 32'h200, 6'd0);
    resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 6'd0, 1'b1, 32'h104);
    tick();
    lookup(1'b1, 32'h100, 1'b0, 32'h104, 6'd0);
    resolve(32'h100, 1'b0, 32'h0, 1'b0, 32'h104, 6'd0, 1'b0, 32'h104);
    tick();
    lookup(1'b1, 32'h100, 1'b0, 32'h104, 6'd0);
    resolve(32'h100, 1'b0, 32'h0, 1'b0, 32'h104, 6'd0, 1'b0, 32'h104);
    tick();

    // Train up from the floor: 0 -> 1 (still not taken) -> 2
    lookup(1'b1, 32'h100, 1'b0, 32'h104, 6'd0);
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 6'd0, 1'b1, 32'h200);
    tick();
    lookup(1'b1, 32'h100, 1'b0, 32'h104, 6'd0);
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 6'd0, 1'b1, 32'h200);
    tick();
    lookup(1'b1, 32'h100, 1'b1, 32'h200, 6'd0);
    tick();

    // Wrong target: predicted 0x200, actual 0x300. Counter goes to 3.
    lookup(1'b1, 32'h100, 1'b1, 32'h200, 6'd0);
    resolve(32'h100, 1'b1, 32'h300, 1'b1, 32'h200, 6'd0, 1'b1, 32'h300);
    tick();
    // Correct taken prediction. The counter saturates at 3.
    lookup(1'b1, 32'h100, 1'b1, 32'h300, 6'd0);
    resolve(32'h100, 1'b1, 32'h300, 1'b1, 32'h300, 6'd0, 1'b0, 32'h300);
    tick();
    // One not-taken: 3 -> 2, still predicts taken
    lookup(1'b1, 32'h100, 1'b1, 32'h300, 6'd0);
    resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h300, 6'd0, 1'b1, 32'h104);
    tick();

    // Correct not-taken at the top of the address space. The PC+4 wraps.
    lookup(1'b1, 32'h100, 1'b1, 32'h300, 6'd0);
    resolve(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 6'h3F, 1'b0, 32'h0);
    tick();
    lookup(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 6'h3F);
    tick();

    // A mispredict is captured, then reset lands right after that edge
    lookup(1'b1, 32'h100, 1'b1, 32'h300, 6'd0);
    resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h300, 6'd0, 1'b1, 32'h104);
    tick();
    rst_n = 1'b0;
    lookup(1'b1, 32'h100, 1'b0, 32'h104, 6'd0);
    tick();
    rst_n = 1'b1;
    lookup(1'b1, 32'h100, 1'b0, 32'h104, 6'd0);
    tick();
    tick();
    tick();

    chk("lookup_queue_drained",  lk_q.size(), 32'd0);
    chk("resolve_queue_drained", rs_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
